// File: rtl/fc_quant_sched.sv
// fc_quant_sched: sequences one FC layer of accumulator results through the
// shared quantizer and packs the returned bytes four per word into SRAM.
module fc_quant_sched #(
    parameter int FC1_OUT_NUM = 500,
    parameter int FC2_OUT_NUM = 10,
    parameter int FC1_BASE    = 0,
    parameter int FC2_BASE    = 128,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              start,
    input  logic              fc_sel,
    input  logic              acc_valid,
    input  logic [31:0]       acc_data,
    output logic              acc_ready,
    output logic              q_fc_state,
    output logic [31:0]       q_unq_data,
    input  logic [7:0]        q_data,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              busy,
    output logic              done
);

    localparam int MAX_N = (FC1_OUT_NUM > FC2_OUT_NUM) ? FC1_OUT_NUM : FC2_OUT_NUM;
    localparam int CNT_W = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state, state_nx;
    logic                layer;
    logic [CNT_W-1:0]    in_cnt;
    logic [CNT_W-1:0]    out_cnt;
    logic [CNT_W-1:0]    n_total;
    logic [CNT_W-1:0]    n_last;
    logic [31:0]         pack;
    logic [31:0]         pack_merged;
    logic [ADDR_W-1:0]   word_addr;
    logic                q_vld;
    logic                accept;
    logic                word_full;

    assign n_total    = layer ? CNT_W'(FC2_OUT_NUM) : CNT_W'(FC1_OUT_NUM);
    assign n_last     = layer ? CNT_W'(FC2_OUT_NUM - 1) : CNT_W'(FC1_OUT_NUM - 1);
    assign acc_ready  = (state == S_RUN) && (in_cnt < n_total);
    assign accept     = acc_valid && acc_ready;
    assign q_fc_state = layer;
    assign q_unq_data = acc_data;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign word_full  = (out_cnt[1:0] == 2'd3) || (out_cnt == n_last);

    // State register.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; DRAIN holds until the final capture has been written.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (accept && (in_cnt == n_last)) state_nx = S_DRAIN;
            S_DRAIN: if (!q_vld) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Merge the returning quantized byte into its lane of the pack word.
    always_comb begin
        pack_merged = pack;
        case (out_cnt[1:0])
            2'd0: pack_merged[7:0]   = q_data;
            2'd1: pack_merged[15:8]  = q_data;
            2'd2: pack_merged[23:16] = q_data;
            2'd3: pack_merged[31:24] = q_data;
            default: pack_merged = pack;
        endcase
    end

    // Layer latch, counters, capture pipeline and SRAM write registers.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            layer      <= 1'b0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            pack       <= '0;
            word_addr  <= '0;
            q_vld      <= 1'b0;
            sram_wr_en <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_wr_en <= 1'b0;
            q_vld      <= accept;
            if ((state == S_IDLE) && start) begin
                layer     <= fc_sel;
                in_cnt    <= '0;
                out_cnt   <= '0;
                pack      <= '0;
                word_addr <= fc_sel ? ADDR_W'(FC2_BASE) : ADDR_W'(FC1_BASE);
            end
            if (accept) in_cnt <= in_cnt + 1'b1;
            if (q_vld) begin
                out_cnt <= out_cnt + 1'b1;
                if (word_full) begin
                    sram_wr_en <= 1'b1;
                    sram_addr  <= word_addr;
                    sram_wdata <= pack_merged;
                    word_addr  <= word_addr + 1'b1;
                    pack       <= '0;
                end else begin
                    pack <= pack_merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_quant_sched.sv
// tb_fc_quant_sched: randomized self-checking bench for fc_quant_sched with a
// behavioural quantizer and a word-level reference of the expected SRAM image.
module tb_fc_quant_sched;

    logic        clk;
    logic        srstn;
    logic        start;
    logic        fc_sel;
    logic        acc_valid;
    logic [31:0] acc_data;
    logic        acc_ready;
    logic        q_fc_state;
    logic [31:0] q_unq_data;
    logic [7:0]  q_data;
    logic        sram_wr_en;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic        busy;
    logic        done;

    int checks;
    int failures;
    int cyc;
    int last_acc_cyc;
    int stall_err;
    int layer_err;
    logic exp_layer;
    logic acc_h1, acc_h2;
    logic [31:0] vals[$];
    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    fc_quant_sched #(
        .FC1_OUT_NUM(500),
        .FC2_OUT_NUM(10),
        .FC1_BASE(0),
        .FC2_BASE(128),
        .ADDR_W(10)
    ) dut (
        .clk(clk),
        .srstn(srstn),
        .start(start),
        .fc_sel(fc_sel),
        .acc_valid(acc_valid),
        .acc_data(acc_data),
        .acc_ready(acc_ready),
        .q_fc_state(q_fc_state),
        .q_unq_data(q_unq_data),
        .q_data(q_data),
        .sram_wr_en(sram_wr_en),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .busy(busy),
        .done(done)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cyc++;

    // Reference quantizer: FC1 is ReLU then rounded /64 capped at 127,
    // FC2 is rounded /32 saturated to signed 8 bits.
    function automatic logic [7:0] quant(input logic [31:0] x, input logic sel);
        longint v;
        v = longint'($signed(x));
        if (!sel) begin
            if (v < 0) v = 0;
            v = (v + 32) >>> 6;
            if (v > 127) v = 127;
        end else begin
            v = (v + 16) >>> 5;
            if (v > 127)  v = 127;
            if (v < -128) v = -128;
        end
        return v[7:0];
    endfunction

    // Stand-in for the shared quantize block: byte valid one cycle after an
    // accept, garbage otherwise so a capture in the wrong cycle is visible.
    always @(posedge clk) begin
        if (acc_valid && acc_ready) q_data <= quant(q_unq_data, q_fc_state);
        else                        q_data <= 8'($urandom);
    end

    // Write monitor: logs writes, flags writes not preceded by an accept two
    // samples earlier, and flags any layer change while busy.
    always @(negedge clk) begin
        if (sram_wr_en) begin
            wr_addr_q.push_back(sram_addr);
            wr_data_q.push_back(sram_wdata);
            if (!acc_h2) stall_err++;
        end
        if (busy && (q_fc_state !== exp_layer)) layer_err++;
        acc_h2 = acc_h1;
        acc_h1 = acc_valid && acc_ready;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(3))
            0: return $urandom;
            1: return 32'($urandom_range(20000));
            2: return 32'(-int'($urandom_range(20000)));
            default: return 32'($urandom_range(9000));
        endcase
    endfunction

    task automatic fill_random(input int n);
        vals.delete();
        for (int i = 0; i < n; i++) vals.push_back(rnd_val());
    endtask

    task automatic start_layer(input logic sel);
        wr_addr_q.delete();
        wr_data_q.delete();
        stall_err = 0;
        layer_err = 0;
        exp_layer = sel;
        start     = 1'b1;
        fc_sel    = sel;
        @(posedge clk); #1;
        start     = 1'b0;
        chk("busy_rise", busy, 1);
        chk("q_fc_state", q_fc_state, sel);
    endtask

    // Offer vals[0..limit-1]; gap is the percentage of idle cycles. At index
    // glitch a start with the opposite layer is pulsed alongside the data.
    task automatic feed(input logic sel, input int gap, input int glitch, input int limit);
        int i;
        int budget;
        bit gl_done;
        i = 0;
        budget = 0;
        gl_done = 0;
        while (i < limit) begin
            acc_valid = ($urandom_range(99) >= gap);
            acc_data  = vals[i];
            start     = (i == glitch) && !gl_done;
            fc_sel    = start ? ~sel : sel;
            if (start) gl_done = 1;
            @(negedge clk);
            if (acc_valid && acc_ready) begin
                i++;
                last_acc_cyc = cyc;
            end
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
            if (budget > 20000) begin
                chk("feed_timeout", 0, 1);
                break;
            end
        end
        acc_valid = 1'b0;
        fc_sel    = sel;
    endtask

    task automatic finish_layer(input logic sel);
        bit found;
        int n;
        int base;
        logic [31:0] ew [0:127];
        logic [7:0]  b;
        n = vals.size();
        base = sel ? 128 : 0;
        found = 0;
        @(negedge clk);
        chk("ready_after_last", acc_ready, 0);
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                chk("done_latency", 64'(cyc - last_acc_cyc), 3);
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("busy_fall", busy, 0);
        for (int j = 0; j < 128; j++) ew[j] = '0;
        for (int i = 0; i < n; i++) begin
            b = quant(vals[i], sel);
            ew[i / 4] = ew[i / 4] | ({24'b0, b} << (8 * (i % 4)));
        end
        chk("wr_count", wr_addr_q.size(), (n + 3) / 4);
        for (int j = 0; j < wr_addr_q.size() && j < (n + 3) / 4; j++) begin
            chk($sformatf("wr_addr[%0d]", j), wr_addr_q[j], 10'(base + j));
            chk($sformatf("wr_data[%0d]", j), wr_data_q[j], ew[j]);
        end
        chk("stall_write", stall_err, 0);
        chk("layer_stable", layer_err, 0);
    endtask

    task automatic run_layer(input logic sel, input int gap, input int glitch);
        start_layer(sel);
        feed(sel, gap, glitch, vals.size());
        finish_layer(sel);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        acc_h1 = 0;
        acc_h2 = 0;
        exp_layer = 0;
        srstn = 1'b0;
        start = 1'b0;
        fc_sel = 1'b0;
        acc_valid = 1'b0;
        acc_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc_ready", acc_ready, 0);
        chk("rst_wr_en", sram_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fc_state", q_fc_state, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        srstn = 1'b1;
        @(posedge clk); #1;

        // FC2, full rate, partial last word.
        fill_random(10);
        run_layer(1'b1, 0, -1);

        // FC1 clamping on the first word.
        fill_random(500);
        vals[0] = 32'h7FFFFFFF;
        vals[1] = 32'(-1000);
        vals[2] = 32'd6400;
        vals[3] = 32'd100;
        run_layer(1'b0, 0, -1);
        if (wr_data_q.size() > 0) chk("fc1_clamp_word0", wr_data_q[0], 32'h0264007F);

        // FC2 signed saturation on the first word.
        fill_random(10);
        vals[0] = 32'(-100000);
        vals[1] = 32'd100000;
        vals[2] = 32'(-48);
        vals[3] = 32'd16;
        run_layer(1'b1, 20, -1);
        if (wr_data_q.size() > 0) chk("fc2_sat_word0", wr_data_q[0], 32'h01FF7F80);

        // FC1 with heavy acc_valid gaps.
        fill_random(500);
        run_layer(1'b0, 60, -1);

        // start pulsed mid-run with the other layer selected.
        fill_random(10);
        run_layer(1'b1, 30, 3);

        // Asynchronous reset after 7 FC1 accepts.
        fill_random(500);
        start_layer(1'b0);
        feed(1'b0, 0, -1, 7);
        #2;
        srstn = 1'b0;
        #1;
        chk("mid_rst_acc_ready", acc_ready, 0);
        chk("mid_rst_wr_en", sram_wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fc_state", q_fc_state, 0);
        chk("mid_rst_addr", sram_addr, 0);
        chk("mid_rst_wdata", sram_wdata, 0);
        @(posedge clk); #1;
        srstn = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        acc_h1 = 0;
        acc_h2 = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_no_write", wr_addr_q.size(), 0);
        fill_random(10);
        run_layer(1'b1, 10, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
